// File: rtl/immgen_stage_if.sv
// immgen_stage_if: handshake bundle for the immediate-generation stage.
//   Upstream  : in_valid/in_ready handshake carrying in_instr, in_sel, in_tag.
//   Downstream: out_valid/out_ready handshake carrying out_imm, out_tag.
//   master modport = the side that feeds the stage and consumes its output.
//   slave  modport = the stage itself.
interface immgen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_sel, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_sel, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag
    );
endinterface

// File: rtl/immgen_stage.sv
// immgen_stage: registered immediate generator with a two-entry skid buffer.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (wins over flush and handshakes)
//   flush  : synchronous kill of both buffered entries
//   bus    : immgen_stage_if.slave
//            in_*  : instruction word, format select (0 NONE,1 I,2 S,3 B,
//                    4 U,5 J,6 Z,7 SH) and tag, valid/ready handshake
//            out_* : generated immediate and its tag, valid/ready handshake
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, holds with its payload until the transfer;
// ready may toggle freely. in_ready is a flop-driven signal (the inverse of
// the skid valid bit) so out_ready never reaches in_ready combinationally.
module immgen_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    immgen_stage_if.slave bus
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("immgen_stage: XLEN must be 32 or 64");
    end

    localparam logic [2:0] SEL_I  = 3'd1;
    localparam logic [2:0] SEL_S  = 3'd2;
    localparam logic [2:0] SEL_B  = 3'd3;
    localparam logic [2:0] SEL_U  = 3'd4;
    localparam logic [2:0] SEL_J  = 3'd5;
    localparam logic [2:0] SEL_Z  = 3'd6;
    localparam logic [2:0] SEL_SH = 3'd7;

    logic [31:0]      instr;
    logic [63:0]      imm_full;   // built at 64 bits, then cut to XLEN
    logic [XLEN-1:0]  imm_next;

    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             drain;
    logic             unused_sink;

    assign instr = bus.in_instr;

    always_comb begin
        imm_full = '0;
        case (bus.in_sel)
            SEL_I:  imm_full = {{52{instr[31]}}, instr[31:20]};
            SEL_S:  imm_full = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            SEL_B:  imm_full = {{51{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            SEL_U:  imm_full = {{32{instr[31]}}, instr[31:12], 12'b0};
            SEL_J:  imm_full = {{43{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            SEL_Z:  imm_full = {59'b0, instr[19:15]};
            // Shift amount is one bit wider on a 64-bit datapath.
            SEL_SH: imm_full = (XLEN == 64) ? {58'b0, instr[25:20]}
                                            : {59'b0, instr[24:20]};
            default: imm_full = '0;
        endcase
    end

    assign imm_next = imm_full[XLEN-1:0];

    // Opcode bits and the upper half on XLEN=32 are intentionally not used.
    assign unused_sink = ^{instr[6:0], imm_full};

    assign accept = bus.in_valid & ~skid_valid;
    assign drain  = main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            // Payload registers keep their value; only the entries die.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (drain && skid_valid) begin
                // in_ready is low while skid holds data, so no accept here.
                main_valid <= 1'b1;
                main_imm   <= skid_imm;
                main_tag   <= skid_tag;
                skid_valid <= 1'b0;
            end else if (accept && (!main_valid || drain)) begin
                main_valid <= 1'b1;
                main_imm   <= imm_next;
                main_tag   <= bus.in_tag;
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_imm   <= imm_next;
                skid_tag   <= bus.in_tag;
            end else if (drain) begin
                main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ~skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_imm   = main_imm;
    assign bus.out_tag   = main_tag;

endmodule

// File: tb/tb_immgen_stage.sv
// tb_immgen_stage: directed bench for immgen_stage at XLEN=32 and XLEN=64.
//   A vector table covers every immediate format on both widths; hand-written
//   sequences cover backpressure, flush and mid-operation reset on the
//   32-bit instance, with an ordered tag queue checking every drain.
module tb_immgen_stage;

    logic clk;
    logic rst_n;
    logic flush32;
    logic flush64;

    immgen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
    immgen_stage_if #(.XLEN(64), .TAG_W(16)) b64 ();

    immgen_stage #(.XLEN(32), .TAG_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(b32)
    );
    immgen_stage #(.XLEN(64), .TAG_W(16)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64), .bus(b64)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every drain on the 32-bit instance must match the next expected tag.
    always @(negedge clk) begin
        if (mon_en && rst_n && !flush32 && b32.out_valid && b32.out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_unexpected: got tag %h expected none",
                         b32.out_tag);
            end else begin
                check("drain_tag", {32'b0, b32.out_tag}, {32'b0, exp_q.pop_front()});
            end
        end else if (mon_en && rst_n && flush32 && b32.out_valid && b32.out_ready) begin
            // A drain in the flush cycle still completes downstream.
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain_flush_unexpected: got tag %h expected none",
                         b32.out_tag);
            end else begin
                check("drain_flush_tag", {32'b0, b32.out_tag}, {32'b0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push32(input logic [31:0] tag, input logic [31:0] instr,
                          input logic [2:0] sel);
        b32.in_valid = 1'b1;
        b32.in_tag   = tag;
        b32.in_instr = instr;
        b32.in_sel   = sel;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          x64;
        logic [31:0] instr;
        logic [2:0]  sel;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{0, 32'hFFF00093, 3'd1, 64'h00000000_FFFFFFFF, "i32_neg1"};
        vecs[1]  = '{0, 32'hFE000EE3, 3'd3, 64'h00000000_FFFFFFFC, "b32_neg4"};
        vecs[2]  = '{0, 32'hFE000EE3, 3'd0, 64'h00000000_00000000, "none32"};
        vecs[3]  = '{0, 32'hFE112E23, 3'd2, 64'h00000000_FFFFFFFC, "s32_neg4"};
        vecs[4]  = '{0, 32'h12345037, 3'd4, 64'h00000000_12345000, "u32_pos"};
        vecs[5]  = '{0, 32'h0080006F, 3'd5, 64'h00000000_00000008, "j32_pos8"};
        vecs[6]  = '{0, 32'hFFDFF06F, 3'd5, 64'h00000000_FFFFFFFC, "j32_neg4"};
        vecs[7]  = '{0, 32'h03F09093, 3'd7, 64'h00000000_0000001F, "sh32_5bit"};
        vecs[8]  = '{0, 32'h000F8073, 3'd6, 64'h00000000_0000001F, "z32_31"};
        vecs[9]  = '{1, 32'h800000B7, 3'd4, 64'hFFFFFFFF_80000000, "u64_neg"};
        vecs[10] = '{1, 32'h03F09093, 3'd7, 64'h00000000_0000003F, "sh64_6bit"};
        vecs[11] = '{1, 32'h000F8073, 3'd6, 64'h00000000_0000001F, "z64_31"};
        vecs[12] = '{1, 32'h7FF00093, 3'd1, 64'h00000000_000007FF, "i64_max"};
        vecs[13] = '{1, 32'hFE000EE3, 3'd3, 64'hFFFFFFFF_FFFFFFFC, "b64_neg4"};
    end

    // ---------------- test ----------------
    initial begin
        rst_n   = 1'b0;
        flush32 = 1'b0;
        flush64 = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_sel = '0; b32.in_tag = '0;
        b32.out_ready = 1'b0;
        b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_sel = '0; b64.in_tag = '0;
        b64.out_ready = 1'b0;

        repeat (3) tick();
        check("rst_valid32", {63'b0, b32.out_valid}, 64'd0);
        check("rst_ready32", {63'b0, b32.in_ready},  64'd1);
        check("rst_imm32",   {32'b0, b32.out_imm},   64'd0);
        check("rst_tag32",   {32'b0, b32.out_tag},   64'd0);
        check("rst_valid64", {63'b0, b64.out_valid}, 64'd0);
        check("rst_ready64", {63'b0, b64.in_ready},  64'd1);
        check("rst_imm64",   b64.out_imm,            64'd0);
        rst_n = 1'b1;
        tick();

        // Table: one entry per vector, latency 1, then drain and hold check.
        for (int k = 0; k < 14; k++) begin
            b32.out_ready = 1'b1;
            b64.out_ready = 1'b1;
            if (vecs[k].x64) begin
                b64.in_valid = 1'b1; b64.in_instr = vecs[k].instr;
                b64.in_sel = vecs[k].sel; b64.in_tag = 16'(k + 100);
            end else begin
                push32(32'(k + 100), vecs[k].instr, vecs[k].sel);
            end
            tick();
            b32.in_valid = 1'b0;
            b64.in_valid = 1'b0;
            if (vecs[k].x64) begin
                check({vecs[k].name, "_valid"}, {63'b0, b64.out_valid}, 64'd1);
                check(vecs[k].name,              b64.out_imm,            vecs[k].exp);
                check({vecs[k].name, "_tag"},   {48'b0, b64.out_tag},   64'(k + 100));
            end else begin
                check({vecs[k].name, "_valid"}, {63'b0, b32.out_valid}, 64'd1);
                check(vecs[k].name,              {32'b0, b32.out_imm},   vecs[k].exp);
                check({vecs[k].name, "_tag"},   {32'b0, b32.out_tag},   64'(k + 100));
            end
            tick();
            if (vecs[k].x64) begin
                check({vecs[k].name, "_drained"}, {63'b0, b64.out_valid}, 64'd0);
                check({vecs[k].name, "_hold"},    b64.out_imm,            vecs[k].exp);
            end else begin
                check({vecs[k].name, "_drained"}, {63'b0, b32.out_valid}, 64'd0);
                check({vecs[k].name, "_hold"},    {32'b0, b32.out_imm},   vecs[k].exp);
            end
        end

        // Backpressure: tags 1,2 accepted, 3 held by the source.
        mon_en = 1'b1;
        b32.out_ready = 1'b0;
        push32(32'd1, 32'hFFF00093, 3'd1);
        tick();
        check("bp_ready_after1", {63'b0, b32.in_ready}, 64'd1);
        check("bp_tag_after1",   {32'b0, b32.out_tag},  64'd1);
        push32(32'd2, 32'h00100093, 3'd1);
        tick();
        check("bp_ready_after2", {63'b0, b32.in_ready},  64'd0);
        check("bp_valid_after2", {63'b0, b32.out_valid}, 64'd1);
        check("bp_tag_after2",   {32'b0, b32.out_tag},   64'd1);
        push32(32'd3, 32'h00200093, 3'd1);
        tick();
        check("bp_ready_held",   {63'b0, b32.in_ready},  64'd0);
        check("bp_tag_held",     {32'b0, b32.out_tag},   64'd1);
        check("bp_imm_held",     {32'b0, b32.out_imm},   64'h00000000_FFFFFFFF);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd3);
        b32.out_ready = 1'b1;
        tick();
        check("bp_skid_to_main", {32'b0, b32.out_tag},  64'd2);
        check("bp_ready_back",   {63'b0, b32.in_ready}, 64'd1);
        check("bp_imm2",         {32'b0, b32.out_imm},  64'd1);
        tick();
        b32.in_valid = 1'b0;
        check("bp_tag3",         {32'b0, b32.out_tag},   64'd3);
        check("bp_imm3",         {32'b0, b32.out_imm},   64'd2);
        tick();
        check("bp_empty",        {63'b0, b32.out_valid}, 64'd0);
        check("bp_queue_empty",  64'(exp_q.size()),      64'd0);

        // Flush with main and skid full, plus a waiting entry.
        b32.out_ready = 1'b0;
        push32(32'h10, 32'hFFF00093, 3'd1);
        tick();
        push32(32'h11, 32'hFFF00093, 3'd1);
        tick();
        push32(32'h12, 32'hFFF00093, 3'd1);
        flush32 = 1'b1;
        tick();
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        check("fl_full_valid", {63'b0, b32.out_valid}, 64'd0);
        check("fl_full_ready", {63'b0, b32.in_ready},  64'd1);

        // Flush with only main full: the entry accepted in that cycle dies too.
        push32(32'h14, 32'h00000093, 3'd1);
        tick();
        push32(32'h15, 32'h00000093, 3'd1);
        flush32 = 1'b1;
        tick();
        flush32 = 1'b0;
        b32.in_valid = 1'b0;
        check("fl_acc_valid", {63'b0, b32.out_valid}, 64'd0);
        check("fl_acc_ready", {63'b0, b32.in_ready},  64'd1);
        b32.out_ready = 1'b1;
        repeat (2) tick();
        check("fl_nothing_emerges", {63'b0, b32.out_valid}, 64'd0);

        // Drain in the flush cycle is a completed transfer.
        b32.out_ready = 1'b0;
        push32(32'h16, 32'h00000093, 3'd1);
        tick();
        b32.in_valid = 1'b0;
        exp_q.push_back(32'h16);
        b32.out_ready = 1'b1;
        flush32 = 1'b1;
        tick();
        flush32 = 1'b0;
        check("fl_drain_valid", {63'b0, b32.out_valid}, 64'd0);
        check("fl_drain_queue", 64'(exp_q.size()),      64'd0);

        // Reset mid-operation with both entries full and in_valid high.
        b32.out_ready = 1'b0;
        push32(32'h20, 32'hFFF00093, 3'd1);
        tick();
        push32(32'h21, 32'hFFF00093, 3'd1);
        tick();
        push32(32'h22, 32'hFFF00093, 3'd1);
        rst_n = 1'b0;
        tick();
        check("mr_valid", {63'b0, b32.out_valid}, 64'd0);
        check("mr_imm",   {32'b0, b32.out_imm},   64'd0);
        check("mr_tag",   {32'b0, b32.out_tag},   64'd0);
        check("mr_ready", {63'b0, b32.in_ready},  64'd1);
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        exp_q.push_back(32'h23);
        push32(32'h23, 32'hFFF00093, 3'd1);
        tick();
        b32.in_valid = 1'b0;
        check("mr_resume_valid", {63'b0, b32.out_valid}, 64'd1);
        check("mr_resume_tag",   {32'b0, b32.out_tag},   64'h23);
        check("mr_resume_imm",   {32'b0, b32.out_imm},   64'h00000000_FFFFFFFF);
        tick();
        check("mr_drained",      {63'b0, b32.out_valid}, 64'd0);
        check("final_queue",     64'(exp_q.size()),      64'd0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/immgen_stage.md
# immgen_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It supports 32- and 64-bit datapaths and adds CSR zimm and shift-amount formats. A two-entry skid buffer with a valid/ready handshake sits between fetch/decode and the register-read stage. A carried tag (PC or instruction ID) stays aligned with each immediate, and a synchronous flush drops in-flight entries on redirect.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- TAG_W, 32: width of the sideband tag carried with each entry.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous kill of all buffered entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  32  raw instruction word.
- in_sel  input  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 SH.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_tag  output  TAG_W  tag of the output entry.

## Operation
- Immediate is computed combinationally from in_instr/in_sel at accept time, and the result is stored; the raw instruction is not stored.
- Sign extension is from instr[31] to XLEN for the I, S, B, U and J formats.
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; when XLEN=64, bits 63:32 equal instr[31].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Z: instr[19:15] zero-extended.
- SH: instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64), zero-extended.
- NONE: all zeros.
- Storage is an output register (main) plus one skid register, each with its own valid bit.
- Accept means in_valid & in_ready. Drain means out_valid & out_ready.
- On accept:
  - If main is empty, or is draining this cycle while skid is empty, the entry loads into main.
  - Otherwise it loads into skid.
- On drain with skid valid, skid moves to main. A simultaneous accept is impossible, because in_ready is 0 whenever skid is valid.
- Order is strictly FIFO; entries are never duplicated or lost except by flush.
- in_ready equals the negation of the skid valid bit, registered from state.
- Flush:
  - Next cycle, both valid bits are 0 and in_ready is 1.
  - An entry accepted in the flush cycle is discarded.
  - A drain in the flush cycle still counts as completed downstream.
- Reset:
  - While rst_n is low, inputs are ignored.
  - Outputs: out_valid 0, out_imm 0, out_tag 0, in_ready 1.
  - Reset takes precedence over flush and over all handshakes.
- out_imm/out_tag hold their last value when out_valid is 0, and change only on a load into main.
- Illegal XLEN is a static elaboration error.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears with out_valid=1 after edge N.
- Throughput is 1 entry per cycle with out_ready held high.
- With out_ready low, main and skid fill, and in_ready falls the cycle after the second accept.
- After out_ready returns, the skid entry is in main one cycle after the drain, and in_ready is 1 in that same cycle.
- No combinational path exists from out_ready to in_ready. The only combinational paths are in_instr/in_sel to the internal immediate logic, before the register.
- Reset mid-operation: all entries are lost; state equals post-reset state on the next edge.

## Test plan
- XLEN=32, in_instr=0xFFF00093, sel I, out_ready=1 → one cycle later out_valid=1, out_imm=0xFFFFFFFF, tag echoed.
- XLEN=32, in_instr=0xFE000EE3, sel B → out_imm=0xFFFFFFFC; same word with sel NONE → 0x00000000.
- XLEN=64:
  - in_instr=0x800000B7, sel U → out_imm=0xFFFFFFFF80000000.
  - in_instr=0x03F09093, sel SH → 0x000000000000003F.
  - Zimm field 31, sel Z → 0x000000000000001F.
- Backpressure, out_ready=0:
  - Push tags 1, 2, 3 on consecutive cycles → tags 1 and 2 accepted; in_ready=0 from the cycle after tag 2; tag 3 is held by the source.
  - Raise out_ready → tags emerge 1, 2, 3 in consecutive cycles with no gaps or duplicates.
- Flush with main and skid full, plus in_valid=1 in the flush cycle → next cycle out_valid=0 and in_ready=1; the flushed and flush-cycle entries never appear.
- Assert rst_n=0 for one cycle with both entries full and in_valid=1 → out_valid=0, out_imm=0, out_tag=0, in_ready=1 after the edge; normal operation resumes the following cycle.
